counter_timer_high: RTL
=======================

COUNTER_TIMER_HIGH -- requirements
Module: counter_timer_high

Interface
REQ-001 SHALL have port clkin, input, 1: sole clock, all state on rising edge.
REQ-002 SHALL have port resetn, input, 1: reset, asynchronous, active-low.
REQ-003 SHALL have ports reg_cfg_we (in, 1), reg_cfg_di (in, 32), reg_cfg_do (out, 32): config register write strobe, write data, readback.
REQ-004 SHALL have ports reg_val_we (in, 4), reg_val_di (in, 32), reg_val_do (out, 32): stop/reload value, per-byte write enables.
REQ-005 SHALL have ports reg_dat_we (in, 4), reg_dat_di (in, 32), reg_dat_do (out, 32): current count, per-byte write enables.
REQ-006 SHALL have inputs enable_in, strobe, is_offset, stop_in (1 each), driven by the paired low-word counter: its enable, its rollover strobe, its offset flag, and its stop flag.
REQ-007 SHALL have outputs stop_out, enable_out, irq_out (1 each); stop_out drives the low-word counter's stop input.

Function
REQ-008 SHALL decode config bits [0] enable, [1] oneshot, [2] updown (1=up), [3] chain, [4] irq_ena; reg_cfg_do = {27'd0, irq_ena, chain, updown, oneshot, enable}.
REQ-009 SHALL set enable_out = enable and loc_enable = chain ? (enable & enable_in) : enable.
REQ-010 SHALL set reg_val_do = value_reset and reg_dat_do = value_cur; byte lanes SHALL be written only where the matching we bit is set.
REQ-011 SHALL give any nonzero reg_dat_we priority over counting: counting is suspended that cycle, and stop_out and irq_out are held.
REQ-012 SHALL treat the first enabled cycle (loc_enable=1, previous-cycle loc_enable=0) as start: load value_cur = up ? 0 : value_reset and stop_out <= (loaded value == target).
REQ-013 SHALL set target = down ? 0 : (chain & is_offset ? value_reset-1 : value_reset), with 32-bit wrap (value_reset=0 with offset gives 0xFFFFFFFF).
REQ-014 SHALL define the advance condition as: chain=0, every enabled non-start cycle; chain=1, only enabled non-start cycles with strobe=1.
REQ-015 SHALL define the terminal condition as: chain=0, stop_out=1; chain=1, stop_out=1 and stop_in=1.
REQ-016 On an advance cycle with the terminal condition met: oneshot=1 SHALL hold value_cur with stop_out=1; oneshot=0 SHALL reload value_cur (up: 0, down: value_reset) and set stop_out <= (reload value == target).
REQ-017 On an advance cycle without the terminal condition: SHALL set value_cur <= value_cur±1 (mod 2^32) and stop_out <= (new value == target).
REQ-018 In chain=1, on cycles without strobe: value_cur SHALL be held; a terminal condition SHALL be acted on per REQ-016 regardless of strobe.
REQ-019 SHALL pulse irq_out for exactly one cycle, one cycle after the terminal condition is first seen, when irq_ena=1; a held oneshot terminal SHALL NOT re-pulse.
REQ-020 When loc_enable=0: value_cur and stop_out SHALL hold; irq_out SHALL be 0.

Reset
REQ-021 On resetn=0 (asynchronous), SHALL clear all config bits, value_reset, value_cur, stop_out, irq_out, and the previous-enable flag to 0; all outputs read 0.
REQ-022 Reset asserted mid-count SHALL abort immediately; after release, the counter stays idle until enable is rewritten.

Configuration
REQ-023 With macro COUNTER_TIMER_HIGH_IRQ_EN defined: irq_ena and irq_out SHALL behave per REQ-019.
REQ-024 Without COUNTER_TIMER_HIGH_IRQ_EN: irq_out SHALL be tied 0, cfg bit 4 SHALL be unimplemented and read 0, and no irq logic SHALL be present.

Verification
REQ-025 chain=0, up, value_reset=3, oneshot=0, enable: reg_dat_do SHALL read 0,1,2,3,0,…; stop_out SHALL be high while value is 3.
REQ-026 chain=0, down, oneshot=1, value_reset=2, irq_ena=1: count SHALL go 2,1,0 and hold 0; stop_out=1 from the value-0 cycle; irq_out SHALL pulse once, one cycle after the first terminal cycle.
REQ-027 chain=1, up, value_reset=2, is_offset=0, enable_in=1, strobe pulsed every 4 cycles: value SHALL advance only on strobe cycles; stop_out=1 at value 2; stop_in=1 in that state SHALL reload to 0.
REQ-028 chain=1, up, value_reset=0, is_offset=1: target SHALL be 0xFFFFFFFF; stop_out SHALL be 0 at start and SHALL assert after a reg_dat write of 0xFFFFFFFE followed by one strobe.
REQ-029 Simultaneous reg_dat_we=4'b0011 (data 0x0000ABCD) and strobe: value_cur[15:0] SHALL become 0xABCD, upper bytes unchanged, no increment that cycle.
REQ-030 resetn pulsed low mid-count (value 5): all outputs SHALL read 0 immediately; counter SHALL stay idle after release until cfg is rewritten.

Source files
------------

// File: rtl/counter_timer_high.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// counter_timer_high
//
// Upper-word half of a 32/64-bit counter/timer. Standalone (chain=0) it is a
// free-running 32-bit up/down counter with a stop/reload value. Chained
// (chain=1) it advances only on the low-word counter's rollover strobe, and
// it reaches its terminal state only when both halves are at their stop
// values.
//
// Optional feature macro: COUNTER_TIMER_HIGH_IRQ_EN
//   defined   : config bit 4 (irq_ena) exists, irq_out pulses on terminal
//   undefined : config bit 4 reads 0, irq_out is tied low
//
// Ports
//   clkin        in   clock, all state on the rising edge
//   resetn       in   asynchronous active-low reset
//   reg_cfg_we   in   config write strobe
//   reg_cfg_di   in   config write data  {.., irq_ena, chain, updown, oneshot, enable}
//   reg_cfg_do   out  config readback
//   reg_val_we   in   per-byte write enables for the stop/reload value
//   reg_val_di   in   stop/reload value write data
//   reg_val_do   out  stop/reload value readback
//   reg_dat_we   in   per-byte write enables for the current count
//   reg_dat_di   in   current count write data
//   reg_dat_do   out  current count readback
//   enable_in    in   low-word counter enable
//   strobe       in   low-word counter rollover strobe
//   is_offset    in   low-word counter offset flag
//   stop_in      in   low-word counter stop flag
//   stop_out     out  this counter is at its target (feeds low word stop input)
//   enable_out   out  config enable bit
//   irq_out      out  one-cycle terminal interrupt pulse
// ---------------------------------------------------------------------------
module counter_timer_high (
   input  logic        clkin,
   input  logic        resetn,
   input  logic        reg_cfg_we,
   input  logic [31:0] reg_cfg_di,
   output logic [31:0] reg_cfg_do,
   input  logic [3:0]  reg_val_we,
   input  logic [31:0] reg_val_di,
   output logic [31:0] reg_val_do,
   input  logic [3:0]  reg_dat_we,
   input  logic [31:0] reg_dat_di,
   output logic [31:0] reg_dat_do,
   input  logic        enable_in,
   input  logic        strobe,
   input  logic        is_offset,
   input  logic        stop_in,
   output logic        stop_out,
   output logic        enable_out,
   output logic        irq_out
);

   localparam int DATA_W = 32;

   logic              cfg_enable;
   logic              cfg_oneshot;
   logic              cfg_updown;
   logic              cfg_chain;
   logic              cfg_irq_ena;
   logic [DATA_W-1:0] value_reset;
   logic [DATA_W-1:0] value_cur;
   logic              loc_enable;
   logic              loc_enable_p1;

   logic              dat_wr;
   logic              start;
   logic              advance;
   logic              terminal;
   logic [DATA_W-1:0] target;
   logic [DATA_W-1:0] load_val;
   logic [DATA_W-1:0] step_val;
   logic [DATA_W-1:0] value_nxt;
   logic              stop_nxt;

   function automatic logic [DATA_W-1:0] byte_merge(
      input logic [DATA_W-1:0] old_val,
      input logic [DATA_W-1:0] new_val,
      input logic [3:0]        we
   );
      logic [DATA_W-1:0] res;
      res = old_val;
      for (int b = 0; b < 4; b++) begin
         if (we[b]) res[8*b +: 8] = new_val[8*b +: 8];
      end
      return res;
   endfunction

   // In chained mode the upper word only runs while the low word runs.
   assign loc_enable = cfg_chain ? (cfg_enable & enable_in) : cfg_enable;
   assign dat_wr     = |reg_dat_we;
   assign start      = loc_enable & ~loc_enable_p1;

   // An offset low word stops one count early, so the upper word must too.
   // value_reset = 0 wraps to all-ones here on purpose.
   assign target   = ~cfg_updown ? '0 :
                     (cfg_chain & is_offset) ? (value_reset - 32'd1) : value_reset;
   assign load_val = cfg_updown ? '0 : value_reset;
   assign step_val = cfg_updown ? (value_cur + 32'd1) : (value_cur - 32'd1);

   assign advance  = loc_enable & ~start & (~cfg_chain | strobe);
   // Terminal is acted on even without a strobe when chained.
   assign terminal = loc_enable & ~start & stop_out & (~cfg_chain | stop_in);

   always_comb begin
      value_nxt = value_cur;
      stop_nxt  = stop_out;
      if (dat_wr) begin
         // Software write wins over counting; stop flag is frozen.
         value_nxt = byte_merge(value_cur, reg_dat_di, reg_dat_we);
      end else if (start) begin
         value_nxt = load_val;
         stop_nxt  = (load_val == target);
      end else if (terminal) begin
         if (!cfg_oneshot) begin
            value_nxt = load_val;
            stop_nxt  = (load_val == target);
         end
      end else if (advance) begin
         value_nxt = step_val;
         stop_nxt  = (step_val == target);
      end
   end

   // Register stage: configuration and value registers.
   always_ff @(posedge clkin or negedge resetn) begin
      if (!resetn) begin
         cfg_enable  <= 1'b0;
         cfg_oneshot <= 1'b0;
         cfg_updown  <= 1'b0;
         cfg_chain   <= 1'b0;
         value_reset <= '0;
      end else begin
         if (reg_cfg_we) begin
            cfg_enable  <= reg_cfg_di[0];
            cfg_oneshot <= reg_cfg_di[1];
            cfg_updown  <= reg_cfg_di[2];
            cfg_chain   <= reg_cfg_di[3];
         end
         value_reset <= byte_merge(value_reset, reg_val_di, reg_val_we);
      end
   end

   // Register stage: count, stop flag and start detection.
   always_ff @(posedge clkin or negedge resetn) begin
      if (!resetn) begin
         value_cur     <= '0;
         stop_out      <= 1'b0;
         loc_enable_p1 <= 1'b0;
      end else begin
         value_cur     <= value_nxt;
         stop_out      <= stop_nxt;
         loc_enable_p1 <= loc_enable;
      end
   end

`ifdef COUNTER_TIMER_HIGH_IRQ_EN
   logic irq_q;
   logic terminal_p1;
   logic cfg_di_unused;

   assign cfg_di_unused = &{1'b0, reg_cfg_di[31:5]};

   // Register stage: interrupt. terminal_p1 suppresses re-pulsing while a
   // oneshot counter sits in its terminal state.
   always_ff @(posedge clkin or negedge resetn) begin
      if (!resetn) begin
         cfg_irq_ena <= 1'b0;
         irq_q       <= 1'b0;
         terminal_p1 <= 1'b0;
      end else begin
         if (reg_cfg_we) cfg_irq_ena <= reg_cfg_di[4];
         if (dat_wr) begin
            irq_q       <= irq_q;
            terminal_p1 <= terminal_p1;
         end else if (!loc_enable || start) begin
            irq_q       <= 1'b0;
            terminal_p1 <= 1'b0;
         end else begin
            irq_q       <= cfg_irq_ena & terminal & ~terminal_p1;
            terminal_p1 <= terminal;
         end
      end
   end

   assign irq_out = irq_q & loc_enable;
`else
   logic cfg_di_unused;

   assign cfg_di_unused = &{1'b0, reg_cfg_di[31:4]};
   assign cfg_irq_ena   = 1'b0;
   assign irq_out       = 1'b0;
`endif

   assign reg_cfg_do = {27'd0, cfg_irq_ena, cfg_chain, cfg_updown, cfg_oneshot, cfg_enable};
   assign reg_val_do = value_reset;
   assign reg_dat_do = value_cur;
   assign enable_out = cfg_enable;

endmodule
